// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares the unified RAM between the instruction-fetch port (i_*) and the
// load/store port (d_*). One RAM transaction is in flight at a time. Data
// requests win arbitration until fetch has been passed over STARVE_LIMIT
// times in a row, after which fetch is granted once.
// Transaction flow: IDLE (arbitrate, launch) -> BUSY (hold until mem_ack)
// -> RESP (one-cycle ack pulse, requests ignored) -> IDLE.
// Optional build macro: ARB_PERF_EN enables the per-port wait-cycle counters
// perf_i_wait / perf_d_wait; without it both ports read as zero.
module rv32i_mem_arbiter #(
   parameter int dataW        = 32,
   parameter int RAMAddrSize  = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_req,
   input  logic [RAMAddrSize-1:0] i_addr,
   output logic                   i_ack,
   output logic [dataW-1:0]       i_rdata,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [RAMAddrSize-1:0] d_addr,
   input  logic [dataW-1:0]       d_wdata,
   input  logic [dataW/8-1:0]     d_be,
   output logic                   d_ack,
   output logic [dataW-1:0]       d_rdata,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [RAMAddrSize-1:0] mem_addr,
   output logic [dataW-1:0]       mem_wdata,
   output logic [dataW/8-1:0]     mem_be,
   input  logic [dataW-1:0]       mem_rdata,
   input  logic                   mem_ack,
   output logic [31:0]            perf_i_wait,
   output logic [31:0]            perf_d_wait
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Saturation point of the starvation counter (limit is at most 15).
   localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

   state_t     state_r;
   logic [3:0] starve_cnt_r;
   logic       grant_d_r;      // 1 = transaction in flight belongs to the data port
   logic       starve_at_max_s;
   logic       d_win_s;
   logic       i_win_s;

   assign starve_at_max_s = (starve_cnt_r == STARVE_MAX);

   // Arbitration decision for the IDLE cycle: data first unless fetch is starved.
   always_comb begin
      d_win_s = 1'b0;
      i_win_s = 1'b0;
      if (d_req && !(i_req && starve_at_max_s)) begin
         d_win_s = 1'b1;
      end else if (i_req) begin
         i_win_s = 1'b1;
      end else begin
         d_win_s = 1'b0;
         i_win_s = 1'b0;
      end
   end

   // Transaction sequencer: launches the granted request, waits for the RAM, pulses the ack.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         starve_cnt_r <= 4'd0;
         grant_d_r    <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {RAMAddrSize{1'b0}};
         mem_wdata    <= {dataW{1'b0}};
         mem_be       <= {(dataW/8){1'b0}};
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         i_rdata      <= {dataW{1'b0}};
         d_rdata      <= {dataW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (d_win_s) begin
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_be    <= d_be;
                  grant_d_r <= 1'b1;
                  state_r   <= ST_BUSY;
                  // Only a data grant that actually passes over a waiting fetch counts.
                  if (i_req) begin
                     starve_cnt_r <= starve_at_max_s ? STARVE_MAX : (starve_cnt_r + 4'd1);
                  end else begin
                     starve_cnt_r <= starve_cnt_r;
                  end
               end else if (i_win_s) begin
                  mem_req      <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_addr     <= i_addr;
                  mem_wdata    <= {dataW{1'b0}};
                  mem_be       <= {(dataW/8){1'b1}};
                  grant_d_r    <= 1'b0;
                  starve_cnt_r <= 4'd0;
                  state_r      <= ST_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state_r <= ST_RESP;
                  if (grant_d_r) begin
                     d_ack <= 1'b1;
                     // Stores leave the last load result untouched.
                     if (!mem_we) begin
                        d_rdata <= mem_rdata;
                     end else begin
                        d_rdata <= d_rdata;
                     end
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= mem_rdata;
                  end
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            ST_RESP: begin
               i_ack   <= 1'b0;
               d_ack   <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               i_ack   <= 1'b0;
               d_ack   <= 1'b0;
               mem_req <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ARB_PERF_EN
   // Wait-cycle counters: a cycle counts while a port requests and is not being acked.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_i_wait <= 32'd0;
         perf_d_wait <= 32'd0;
      end else begin
         if (i_req && !i_ack) begin
            perf_i_wait <= perf_i_wait + 32'd1;
         end else begin
            perf_i_wait <= perf_i_wait;
         end
         if (d_req && !d_ack) begin
            perf_d_wait <= perf_d_wait + 32'd1;
         end else begin
            perf_d_wait <= perf_d_wait;
         end
      end
   end
`else
   assign perf_i_wait = 32'd0;
   assign perf_d_wait = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed scenarios, a RAM
// responder with programmable wait states, a transaction-level reference
// model and a per-cycle compare process, plus hand-computed literal checks.
module tb_rv32i_mem_arbiter;

   localparam int LIM = 4;

   logic        clock, reset;
   logic        i_req, i_ack, d_req, d_we, d_ack;
   logic [15:0] i_addr, d_addr, mem_addr;
   logic [31:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic [3:0]  d_be, mem_be;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] perf_i_wait, perf_d_wait;

   rv32i_mem_arbiter #(.dataW(32), .RAMAddrSize(16), .STARVE_LIMIT(LIM)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always #5 clock = ~clock;

   // ---------------- RAM responder ----------------
   logic [31:0] ram [0:255];
   bit          ram_auto;
   int          ram_wait;
   int          ram_cnt;

   initial begin
      ram_cnt = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            mem_ack = 1'b0;
            ram_cnt = 0;
         end else if (!ram_auto) begin
            ram_cnt = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            ram_cnt = 0;
         end else if (mem_req) begin
            if (ram_cnt == ram_wait) begin
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) ram[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
               end else begin
                  mem_rdata = ram[mem_addr[9:2]];
               end
               mem_ack = 1'b1;
            end else begin
               ram_cnt++;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // One transaction at a time; arbitration only when nothing is outstanding
   // and no ack is being shown. Load/fetch data expected = RAM content at grant.
   logic        m_req, m_i_ack, m_d_ack, m_is_d, m_we;
   logic [15:0] m_addr;
   logic [31:0] m_wdata, m_exp, m_i_rdata, m_d_rdata, m_perf_i, m_perf_d;
   logic [3:0]  m_be;
   int          m_starve;

   // Reference model update at each active edge (async reset clears it).
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_req <= 1'b0; m_i_ack <= 1'b0; m_d_ack <= 1'b0; m_is_d <= 1'b0; m_we <= 1'b0;
         m_addr <= 16'd0; m_wdata <= 32'd0; m_be <= 4'd0; m_exp <= 32'd0;
         m_i_rdata <= 32'd0; m_d_rdata <= 32'd0; m_perf_i <= 32'd0; m_perf_d <= 32'd0;
         m_starve <= 0;
      end else begin
`ifdef ARB_PERF_EN
         if (i_req && !m_i_ack) m_perf_i <= m_perf_i + 32'd1;
         if (d_req && !m_d_ack) m_perf_d <= m_perf_d + 32'd1;
`endif
         if (m_i_ack || m_d_ack) begin
            m_i_ack <= 1'b0;
            m_d_ack <= 1'b0;
         end else if (m_req) begin
            if (mem_ack) begin
               m_req <= 1'b0;
               if (m_is_d) begin
                  m_d_ack <= 1'b1;
                  if (!m_we) m_d_rdata <= m_exp;
               end else begin
                  m_i_ack   <= 1'b1;
                  m_i_rdata <= m_exp;
               end
            end
         end else if (d_req && !(i_req && m_starve == LIM)) begin
            m_req <= 1'b1; m_is_d <= 1'b1; m_we <= d_we; m_addr <= d_addr;
            m_wdata <= d_wdata; m_be <= d_be; m_exp <= ram[d_addr[9:2]];
            if (i_req) m_starve <= (m_starve + 1 > LIM) ? LIM : m_starve + 1;
         end else if (i_req) begin
            m_req <= 1'b1; m_is_d <= 1'b0; m_we <= 1'b0; m_addr <= i_addr;
            m_wdata <= 32'd0; m_be <= 4'hF; m_exp <= ram[i_addr[9:2]];
            m_starve <= 0;
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model, away from the active edge.
   always @(negedge clock) begin
      if (reset) begin
         check("cmp_i_ack",   {31'd0, i_ack},   {31'd0, m_i_ack});
         check("cmp_d_ack",   {31'd0, d_ack},   {31'd0, m_d_ack});
         check("cmp_i_rdata", i_rdata, m_i_rdata);
         check("cmp_d_rdata", d_rdata, m_d_rdata);
         check("cmp_mem_req", {31'd0, mem_req}, {31'd0, m_req});
         check("cmp_perf_i",  perf_i_wait, m_perf_i);
         check("cmp_perf_d",  perf_d_wait, m_perf_d);
         if (m_req) begin
            check("cmp_mem_we",    {31'd0, mem_we}, {31'd0, m_we});
            check("cmp_mem_addr",  {16'd0, mem_addr}, {16'd0, m_addr});
            check("cmp_mem_wdata", mem_wdata, m_wdata);
            check("cmp_mem_be",    {28'd0, mem_be}, {28'd0, m_be});
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_mem_we"},  {31'd0, mem_we},  32'd0);
      check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_mem_be"},  {28'd0, mem_be},  32'd0);
      check({tag, "_i_ack"},   {31'd0, i_ack},   32'd0);
      check({tag, "_d_ack"},   {31'd0, d_ack},   32'd0);
      check({tag, "_i_rdata"}, i_rdata, 32'd0);
      check({tag, "_d_rdata"}, d_rdata, 32'd0);
      check({tag, "_perf_i"},  perf_i_wait, 32'd0);
      check({tag, "_perf_d"},  perf_d_wait, 32'd0);
   endtask

   // ---------------- directed stimulus ----------------
   string grants;
   int    dcnt, ngr, hold, cyc;
   bit    prev, seen;

   initial begin
      clock = 1'b0; reset = 1'b0;
      i_req = 1'b0; i_addr = 16'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 16'd0; d_wdata = 32'd0; d_be = 4'd0;
      mem_rdata = 32'd0; mem_ack = 1'b0;
      ram_auto = 1'b1; ram_wait = 0;
      for (int k = 0; k < 256; k++) ram[k] = {16'hA5A5, 8'h00, k[7:0]};
      ram[4]   = 32'hDEADBEEF;   // 0x0010
      ram[8]   = 32'h00000000;   // 0x0020
      ram[128] = 32'hCAFEF00D;   // 0x0200

      repeat (2) @(negedge clock);
      check_all_zero("reset");
      #2 reset = 1'b1;

      // 1: single load, zero-wait RAM
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      @(negedge clock);
      check("load_mem_req_1cyc", {31'd0, mem_req}, 32'd1);
      check("load_mem_addr", {16'd0, mem_addr}, 32'h0010);
      @(negedge clock);
      check("load_d_ack_2cyc", {31'd0, d_ack}, 32'd1);
      check("load_d_rdata", d_rdata, 32'hDEADBEEF);
      d_req = 1'b0;
      repeat (2) @(negedge clock);

      // 2: store with partial byte enables
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h12345678; d_be = 4'b0011;
      @(negedge clock);
      check("store_mem_we",    {31'd0, mem_we}, 32'd1);
      check("store_mem_be",    {28'd0, mem_be}, 32'h3);
      check("store_mem_addr",  {16'd0, mem_addr}, 32'h0020);
      check("store_mem_wdata", mem_wdata, 32'h12345678);
      @(negedge clock);
      check("store_d_ack", {31'd0, d_ack}, 32'd1);
      check("store_d_rdata_kept", d_rdata, 32'hDEADBEEF);
      d_req = 1'b0;
      @(negedge clock);
      check("store_ram_word", ram[8], 32'h00005678);
      @(negedge clock);

      // 3: continuous contention, starvation limit 4
      i_addr = 16'h0100; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 32'h11223344; d_be = 4'b1100;
      i_req = 1'b1; d_req = 1'b1;
      grants = ""; dcnt = 0; ngr = 0; prev = 1'b0;
      for (int c = 0; c < 100 && ngr < 10; c++) begin
         @(negedge clock);
         if (d_ack) dcnt++;
         if (i_ack) check("starve_dacks_at_iack1", dcnt, 32'd4);
         if (mem_req && !prev) begin
            if (mem_addr == 16'h0100) grants = {grants, "I"};
            else grants = {grants, "D"};
            ngr++;
         end
         prev = mem_req;
      end
      i_req = 1'b0; d_req = 1'b0;
      check("starve_grant_count", ngr, 32'd10);
      n_checks++;
      if (grants != "DDDDIDDDDI") begin
         n_errors++;
         $display("FAIL starve_order: got %s, expected DDDDIDDDDI", grants);
      end
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clock);
         if (i_ack) seen = 1'b1;
      end
      check("starve_iack2_seen", {31'd0, seen}, 32'd1);
      check("starve_dacks_at_iack2", dcnt, 32'd8);
      repeat (2) @(negedge clock);

      // 4: fetch with 5 RAM wait states
      ram_wait = 5;
      i_req = 1'b1; i_addr = 16'h0200;
      hold = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clock);
         if (i_ack) seen = 1'b1;
         else if (mem_req) begin
            hold++;
            check("wait_mem_addr_stable", {16'd0, mem_addr}, 32'h0200);
         end
      end
      i_req = 1'b0;
      check("wait_iack_seen", {31'd0, seen}, 32'd1);
      check("wait_hold_cycles", hold, 32'd6);
      check("wait_i_rdata", i_rdata, 32'hCAFEF00D);
      @(negedge clock);
      check("wait_iack_one_cycle", {31'd0, i_ack}, 32'd0);
      repeat (2) @(negedge clock);
      check("wait_i_rdata_held", i_rdata, 32'hCAFEF00D);

      // 5: reset in BUSY, then a stale mem_ack
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      repeat (2) @(negedge clock);
      check("rst_busy_before", {31'd0, mem_req}, 32'd1);
      #2 reset = 1'b0; d_req = 1'b0;
      #1 check_all_zero("rst_mid");
      ram_auto = 1'b0; ram_wait = 0;
      @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      mem_rdata = 32'hBAD0BAD0; mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check_all_zero("rst_stale");
      end
      ram_auto = 1'b1;
      d_req = 1'b1;
      @(negedge clock);
      check("rst_idle_new_grant", {31'd0, mem_req}, 32'd1);
      @(negedge clock);
      check("rst_new_d_ack", {31'd0, d_ack}, 32'd1);
      d_req = 1'b0;
      repeat (2) @(negedge clock);

      // 6: fetch waits behind three data transactions
      #2 reset = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      @(negedge clock);
      i_req = 1'b1; i_addr = 16'h0200;
      dcnt = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (c > 0) @(negedge clock);
         if (d_ack) begin
            dcnt++;
            if (dcnt == 3) d_req = 1'b0;
         end
         if (i_ack) seen = 1'b1;
      end
      check("perf_iack_seen", {31'd0, seen}, 32'd1);
      check("perf_dacks_before", dcnt, 32'd3);
`ifdef ARB_PERF_EN
      check("perf_i_wait_at_iack", perf_i_wait, 32'd10);
`else
      check("perf_i_wait_tied", perf_i_wait, 32'd0);
      check("perf_d_wait_tied", perf_d_wait, 32'd0);
`endif
      i_req = 1'b0;
      repeat (3) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
